// File: rtl/fault_buf_reader_pkg.sv
// Shared types and helpers for the fault buffer read-side sequencer.
package fault_buf_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FROZEN = 3'd1,
    ST_READ   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Output FIFO must absorb every read that can be in flight plus slack for one
  // word waiting and one word being issued, so full-rate streaming never stalls.
  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/fault_buf_fifo.sv
// Small first-word-fall-through FIFO with occupancy count and synchronous clear.
module fault_buf_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for storage, pointers and count; clear overrides push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/fault_buf_reader.sv
// Read-side sequencer for the post-mortem fault capture buffer.
//   state  | meaning
//   IDLE   | waiting for capture to freeze the buffer
//   FROZEN | write pointer latched, waiting for software start
//   READ   | issuing RAM reads oldest-first, throttled by FIFO credit
//   DRAIN  | all reads issued; waiting for returns and last handshake
//   DONE   | one-cycle re-arm pulse to capture side
module fault_buf_reader
  import fault_buf_reader_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              usr_rst,
  input  logic              cap_done,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              frozen,
  output logic              rearm
);

  localparam int DEPTH = fifo_depth(RD_LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = $clog2(DEPTH + RD_LAT + 1);
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_ptr_q, base_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [RD_LAT-1:0] last_sr_q, last_sr_d;
  logic [ADDR_W:0]   len;
  logic [OCC_W-1:0]  in_flight;
  logic              credit, issue, drain_done;
  logic              fifo_valid, fifo_pop;
  logic [DATA_W:0]   fifo_dout;
  logic [CNT_W-1:0]  fifo_count;

  // Reads still travelling through the RAM pipeline.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + OCC_W'(vld_sr_q[i]);
  end

  // Count the word landing this cycle but not the one popping, so credit is conservative.
  assign credit   = (in_flight + OCC_W'(fifo_count)) < OCC_W'(DEPTH);
  assign fifo_pop = fifo_valid && dout_ready;
  // Leave DRAIN on the same edge that takes the final word so rearm follows immediately.
  assign drain_done = (vld_sr_q == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  // FSM next-state, read issue and return-tracking shift registers.
  always_comb begin
    state_d     = state_q;
    base_ptr_d  = base_ptr_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    issue       = 1'b0;
    len         = (rd_len == '0) ? FULL_LEN : {1'b0, rd_len};
    case (state_q)
      ST_IDLE: begin
        if (cap_done) begin
          base_ptr_d = wr_ptr;
          state_d    = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        if (rd_start) begin
          issue_cnt_d = len;
          rd_addr_d   = base_ptr_q - len[ADDR_W-1:0];
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (credit) begin
          issue       = 1'b1;
          rd_addr_d   = rd_addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q - LEN_ONE;
          if (issue_cnt_q == LEN_ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (usr_rst) begin
      state_d     = ST_IDLE;
      base_ptr_d  = '0;
      rd_addr_d   = '0;
      issue_cnt_d = '0;
      issue       = 1'b0;
    end
    vld_sr_d     = vld_sr_q << 1;
    vld_sr_d[0]  = issue;
    last_sr_d    = last_sr_q << 1;
    last_sr_d[0] = issue && (issue_cnt_q == LEN_ONE);
    if (usr_rst) begin
      vld_sr_d  = '0;
      last_sr_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      base_ptr_q  <= '0;
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      vld_sr_q    <= '0;
      last_sr_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_ptr_q  <= base_ptr_d;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      vld_sr_q    <= vld_sr_d;
      last_sr_q   <= last_sr_d;
    end
  end

  fault_buf_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (usr_rst),
    .push  (vld_sr_q[RD_LAT-1]),
    .din   ({last_sr_q[RD_LAT-1], mem_rd_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? rd_addr_q : '0;
  assign dout_valid  = fifo_valid;
  assign dout        = fifo_valid ? fifo_dout[DATA_W-1:0] : '0;
  assign dout_last   = fifo_valid && fifo_dout[DATA_W];
  assign busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign frozen      = (state_q == ST_FROZEN) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign rearm       = (state_q == ST_DONE);

endmodule

// File: tb/tb_fault_buf_reader.sv
// Self-checking bench for fault_buf_reader: RAM model, stream monitor, scenario tasks.
module tb_fault_buf_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;
  localparam int NWORDS = 1 << ADDR_W;
  localparam int FDEPTH = RD_LAT + 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              usr_rst = 1'b0;
  logic              cap_done = 1'b0;
  logic              rd_start = 1'b0;
  logic              dout_ready = 1'b0;
  logic [ADDR_W-1:0] wr_ptr = '0;
  logic [ADDR_W-1:0] rd_len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid, dout_last, busy, frozen, rearm;
  logic [ADDR_W+DATA_W+5:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fault_buf_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .usr_rst     (usr_rst),
    .cap_done    (cap_done),
    .wr_ptr      (wr_ptr),
    .rd_start    (rd_start),
    .rd_len      (rd_len),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .busy        (busy),
    .frozen      (frozen),
    .rearm       (rearm)
  );

  assign outs = {mem_rd_en, mem_rd_addr, dout, dout_valid, dout_last, busy, frozen, rearm};

  // RAM model: fixed RD_LAT pipeline; garbage when no read was issued.
  logic [DATA_W-1:0] ram [NWORDS];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem_rd_en ? ram[mem_rd_addr] : 32'hDEAD_BEEF;
  end
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  // Monitor state
  int cyc = 0, issued = 0, popped = 0, rearm_n = 0;
  int credit_viol = 0, stall_viol = 0;
  int start_cyc = -1, first_valid_cyc = -1, last_hs_cyc = -1, rearm_cyc = -1;
  logic [DATA_W-1:0] got_d[$];
  bit                got_l[$];
  int                got_a[$];
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_dout = '0;
  logic              prev_last = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      cyc++;
      if (rd_start) start_cyc = cyc;
      if (mem_rd_en) begin
        if (issued - popped >= FDEPTH) credit_viol++;
        issued++;
        got_a.push_back(int'(mem_rd_addr));
      end
      if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (!dout_valid || dout !== prev_dout || dout_last !== prev_last)) stall_viol++;
      prev_stall = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_last  = dout_last;
      if (dout_valid && dout_ready) begin
        got_d.push_back(dout);
        got_l.push_back(dout_last);
        popped++;
        last_hs_cyc = cyc;
      end
      if (rearm) begin
        rearm_n++;
        rearm_cyc = cyc;
      end
    end
  end

  task automatic clr_mon();
    issued = 0; popped = 0; rearm_n = 0;
    start_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; rearm_cyc = -1;
    got_d.delete(); got_l.delete(); got_a.delete();
    prev_stall = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int wp);
    wr_ptr = ADDR_W'(wp);
    cap_done = 1'b1;
    tick();
    cap_done = 1'b0;
  endtask

  task automatic start(input int rl);
    rd_len = ADDR_W'(rl);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_rearm(input int duty, input int budget, output bit ok);
    int n0;
    n0 = rearm_n;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      dout_ready = ($urandom_range(0, 99) < duty);
      tick();
      if (rearm_n > n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Reference: oldest word sits len words behind the write pointer, read in address order.
  logic [DATA_W-1:0] exp_d[$];
  int                exp_a[$];
  task automatic build_exp(input int wp, input int rl);
    int len;
    len = (rl == 0) ? NWORDS : rl;
    exp_d.delete();
    exp_a.delete();
    for (int k = 0; k < len; k++) begin
      int a;
      a = (wp + NWORDS - len + k) % NWORDS;
      exp_a.push_back(a);
      exp_d.push_back(ram[a]);
    end
  endtask

  // Index of first disagreement between received and expected stream, -1 if identical.
  function automatic int first_bad();
    int n;
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int k = 0; k < n; k++)
      if (got_d[k] !== exp_d[k] || got_l[k] !== (k == exp_d.size() - 1)) return k;
    if (got_d.size() != exp_d.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outs_held: got %h want 0", outs);
    end
    reset = 1'b1;
    tick();
    tick();
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outs_released: got %h want 0", outs);
    end
  endtask

  task automatic test_full_read();
    bit ok;
    int bad;
    for (int i = 0; i < NWORDS; i++) ram[i] = DATA_W'(i);
    clr_mon();
    dout_ready = 1'b1;
    capture(5);
    n_tests++;
    if (frozen !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_frozen: frozen=%b busy=%b want 1/0", frozen, busy);
    end
    start(0);
    wait_rearm(100, 100, ok);
    build_exp(5, 0);
    bad = first_bad();
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL full_timeout: rearm not seen, got %0d words want 16", got_d.size());
    end
    n_tests++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL full_seq: first bad idx %0d, got %0d words want %0d", bad, got_d.size(), exp_d.size());
    end
    n_tests++;
    if (first_valid_cyc - start_cyc != RD_LAT + 2) begin
      n_fail++;
      $display("FAIL full_latency: got %0d want %0d", first_valid_cyc - start_cyc, RD_LAT + 2);
    end
    n_tests++;
    if (last_hs_cyc - first_valid_cyc != NWORDS - 1) begin
      n_fail++;
      $display("FAIL full_throughput: got span %0d want %0d", last_hs_cyc - first_valid_cyc, NWORDS - 1);
    end
    n_tests++;
    if (rearm_cyc - last_hs_cyc != 1 || rearm_n != 1) begin
      n_fail++;
      $display("FAIL full_rearm: got delay %0d count %0d want 1/1", rearm_cyc - last_hs_cyc, rearm_n);
    end
  endtask

  task automatic test_partial_wrap();
    bit ok;
    int bad;
    int abad;
    for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;
    clr_mon();
    dout_ready = 1'b1;
    capture(2);
    start(6);
    wait_rearm(100, 100, ok);
    build_exp(2, 6);
    bad = first_bad();
    abad = (got_a.size() == exp_a.size()) ? -1 : 0;
    for (int k = 0; k < got_a.size() && k < exp_a.size(); k++)
      if (abad < 0 && got_a[k] != exp_a[k]) abad = k;
    n_tests++;
    if (!ok || bad != -1) begin
      n_fail++;
      $display("FAIL wrap_seq: ok=%0d first bad idx %0d got %0d words want 6", ok, bad, got_d.size());
    end
    n_tests++;
    if (abad != -1) begin
      n_fail++;
      $display("FAIL wrap_addr: first bad idx %0d got %0d addrs want 6 (12..15,0,1)", abad, got_a.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad, wp, rl, cv0, sv0, nbad;
    cv0 = credit_viol;
    sv0 = stall_viol;
    nbad = 0;
    for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;
    for (int it = 0; it < 300; it++) begin
      wp = $urandom_range(0, NWORDS - 1);
      rl = $urandom_range(0, NWORDS - 1);
      clr_mon();
      capture(wp);
      start(rl);
      wait_rearm(30, 400, ok);
      build_exp(wp, rl);
      bad = first_bad();
      n_tests++;
      if (!ok || bad != -1) begin
        n_fail++;
        nbad++;
        if (nbad <= 5)
          $display("FAIL bp_seq it=%0d wp=%0d len=%0d: ok=%0d first bad idx %0d got %0d words want %0d",
                   it, wp, rl, ok, bad, got_d.size(), exp_d.size());
      end
    end
    n_tests++;
    if (credit_viol != cv0) begin
      n_fail++;
      $display("FAIL bp_credit: got %0d issues past credit want 0", credit_viol - cv0);
    end
    n_tests++;
    if (stall_viol != sv0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable stalled cycles want 0", stall_viol - sv0);
    end
  endtask

  task automatic test_ignored();
    bit ok;
    int bad;
    clr_mon();
    dout_ready = 1'b1;
    start(3);
    for (int i = 0; i < 6; i++) tick();
    n_tests++;
    if (issued != 0 || busy !== 1'b0 || frozen !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_start: got issued=%0d busy=%b frozen=%b want 0/0/0", issued, busy, frozen);
    end
    capture(2);
    start(8);
    capture(9);
    start(5);
    wait_rearm(100, 100, ok);
    build_exp(2, 8);
    bad = first_bad();
    n_tests++;
    if (!ok || bad != -1 || issued != 8) begin
      n_fail++;
      $display("FAIL ignore_mid_read: ok=%0d bad idx %0d issued %0d want 8", ok, bad, issued);
    end
    tick();
    n_tests++;
    if (frozen !== 1'b0 || busy !== 1'b0 || rearm_n != 1) begin
      n_fail++;
      $display("FAIL ignore_after: frozen=%b busy=%b rearms=%0d want 0/0/1", frozen, busy, rearm_n);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit hit;
    int bad;
    for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;
    clr_mon();
    dout_ready = 1'b1;
    capture(7);
    start(10);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (got_d.size() >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_wait: got %0d words want 3", got_d.size());
    end
    usr_rst = 1'b1;
    dout_ready = 1'b0;
    tick();
    usr_rst = 1'b0;
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL abort_outs: got %h want 0", outs);
    end
    clr_mon();
    dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (got_d.size() != 0 || rearm_n != 0 || issued != 0 || frozen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got words=%0d rearms=%0d issued=%0d frozen=%b want 0", got_d.size(), rearm_n, issued, frozen);
    end
    clr_mon();
    capture(3);
    start(5);
    wait_rearm(100, 100, ok);
    build_exp(3, 5);
    bad = first_bad();
    n_tests++;
    if (!ok || bad != -1) begin
      n_fail++;
      $display("FAIL abort_recover: ok=%0d first bad idx %0d got %0d words want 5", ok, bad, got_d.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int bad;
    clr_mon();
    dout_ready = 1'b1;
    capture(11);
    start(0);
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL async_outs: got %h want 0", outs);
    end
    tick();
    tick();
    reset = 1'b1;
    clr_mon();
    tick();
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL async_idle: got %h want 0", outs);
    end
    capture(0);
    start(4);
    wait_rearm(100, 100, ok);
    build_exp(0, 4);
    bad = first_bad();
    n_tests++;
    if (!ok || bad != -1) begin
      n_fail++;
      $display("FAIL async_recover: ok=%0d first bad idx %0d got %0d words want 4", ok, bad, got_d.size());
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_read();
    test_partial_wrap();
    test_ignored();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
